// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: per-channel synchroniser, shared tick prescaler and a
// four-state debounce FSM with registered level, rise/fall pulses and an any-change flag.
module multi_debouncer #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned BOUNCE_TICKS = 10,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] bouncy_in,
    output logic [CHANNELS-1:0] debounced_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    localparam int unsigned CntW  = (BOUNCE_TICKS > 1) ? $clog2(BOUNCE_TICKS) : 1;
    localparam int unsigned PcntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0]  CntLast  = CntW'(BOUNCE_TICKS - 1);
    localparam logic [PcntW-1:0] PcntLast = PcntW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StZero      = 2'b00,
        StMaybeOne  = 2'b01,
        StOne       = 2'b10,
        StMaybeZero = 2'b11
    } state_e;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] sync;
    logic [PcntW-1:0]    pcnt_q, pcnt_d;
    logic                tick;
    logic [CHANNELS-1:0] level_d, rise_d, fall_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= bouncy_in;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // With PRESCALE = 1 the counter is pinned at 0 and tick is permanently high.
    always_comb begin
        tick   = (pcnt_q == PcntLast);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pcnt_q <= '0;
        else      pcnt_q <= pcnt_d;
    end

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        state_e          state_q, state_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            rise_c, fall_c;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_c  = 1'b0;
            fall_c  = 1'b0;
            case (state_q)
                StZero: begin
                    if (sync[i]) begin
                        state_d = StMaybeOne;
                        cnt_d   = '0;
                    end
                end
                StOne: begin
                    if (!sync[i]) begin
                        state_d = StMaybeZero;
                        cnt_d   = '0;
                    end
                end
                StMaybeOne: begin
                    if (!sync[i]) begin
                        state_d = StZero;
                    end else if (tick) begin
                        if (cnt_q == CntLast) begin
                            state_d = StOne;
                            rise_c  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StMaybeZero: begin
                    if (sync[i]) begin
                        state_d = StOne;
                    end else if (tick) begin
                        if (cnt_q == CntLast) begin
                            state_d = StZero;
                            fall_c  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StZero;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= StZero;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // A candidate state keeps showing the previously committed level.
        assign level_d[i] = (state_d == StOne) || (state_d == StMaybeZero);
        assign rise_d[i]  = rise_c;
        assign fall_d[i]  = fall_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            debounced_out <= '0;
            rise_pulse    <= '0;
            fall_pulse    <= '0;
            any_change    <= 1'b0;
        end else begin
            debounced_out <= level_d;
            rise_pulse    <= rise_d;
            fall_pulse    <= fall_d;
            any_change    <= |{rise_d, fall_d};
        end
    end

endmodule
